// File: rtl/serial_deserializer_if.sv
// Bundle of the serial receive link and the parallel valid/ready output.
// Signal prefixes are from the receiver's point of view: i_ flows into the
// deserializer, o_ flows out of it.
interface serial_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             i_enable;
    logic             i_sync_n;
    logic             i_in;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_data_out;
    logic             o_out_valid;
    logic             o_busy;
    logic             o_overrun;

    // Driver side: transmitter strobes plus the consumer's ready
    modport master (
        output i_enable,
        output i_sync_n,
        output i_in,
        output i_out_ready,
        input  o_data_out,
        input  o_out_valid,
        input  o_busy,
        input  o_overrun
    );

    // Receiver side: the deserializer itself
    modport slave (
        input  i_enable,
        input  i_sync_n,
        input  i_in,
        input  i_out_ready,
        output o_data_out,
        output o_out_valid,
        output o_busy,
        output o_overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// LSB-first serial-in, parallel-out receiver with a one-word valid/ready
// output buffer and sticky overrun flag. A low sync_n starts (or restarts)
// a frame; WIDTH enabled edges later the assembled word is offered.
module serial_deserializer #(
    parameter int WIDTH = 4
) (
    input logic                  i_clk,
    input logic                  i_rst,
    serial_deserializer_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_consume;

    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_overrun;

    // The incoming bit always enters at the MSB so the first bit ends up at bit 0
    assign w_word    = {bus.i_in, r_sh[WIDTH-1:1]};
    assign w_consume = r_out_valid & bus.i_out_ready;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, shift/count updates and word completion; sync beats enable
    always_comb begin
        w_state_next = r_state;
        w_sh_next    = r_sh;
        w_cnt_next   = r_cnt;
        w_complete   = 1'b0;
        if (!bus.i_sync_n) begin
            w_state_next = RECV;
            w_sh_next    = '0;
            w_cnt_next   = '0;
        end else if (r_state == RECV && bus.i_enable) begin
            w_sh_next = w_word;
            if (r_cnt == LAST_BIT) begin
                w_complete   = 1'b1;
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // Shift register and bit counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else begin
            r_sh  <= w_sh_next;
            r_cnt <= w_cnt_next;
        end
    end

    // Output buffer: a consume this edge frees the slot for a word completing now
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete) begin
                if (!r_out_valid || w_consume) begin
                    r_data_out  <= w_word;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.o_data_out  = r_data_out;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_overrun   = r_overrun;
    assign bus.o_busy      = (r_state == RECV);
endmodule

// File: tb/tb_serial_deserializer.sv
// Testbench for serial_deserializer: directed scenarios plus a randomized
// run compared against a queue-based model of the frame/buffer rules.
module tb_serial_deserializer;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_deserializer_if #(.WIDTH(W)) bus ();

    serial_deserializer #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits collected so far in the open frame, and the buffer
    logic         mQ[$];
    bit           mActive;
    logic [W-1:0] mData;
    bit           mValid;
    bit           mOverrun;

    task automatic modelReset();
        mQ.delete();
        mActive  = 0;
        mData    = '0;
        mValid   = 0;
        mOverrun = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, clock it, update the model,
    // and leave the caller 1 time unit after the rising edge for sampling
    task automatic tick(input bit en, input bit syncN, input bit b, input bit rdy);
        bit           completed;
        bit           consume;
        logic [W-1:0] word;
        @(negedge clk);
        bus.i_enable    = en;
        bus.i_sync_n    = syncN;
        bus.i_in        = b;
        bus.i_out_ready = rdy;
        @(posedge clk);
        completed = 0;
        consume   = mValid && rdy;
        word      = '0;
        if (!syncN) begin
            mQ.delete();
            mActive = 1;
        end else if (mActive && en) begin
            mQ.push_back(b);
            if (mQ.size() == W) begin
                for (int i = 0; i < W; i++) word[i] = mQ[i];
                mQ.delete();
                mActive   = 0;
                completed = 1;
            end
        end
        if (completed) begin
            if (!mValid || consume) begin
                mData  = word;
                mValid = 1;
            end else begin
                mOverrun = 1;
            end
        end else if (consume) begin
            mValid = 0;
        end
        #1;
    endtask

    // Sync cycle followed by W consecutive enabled bits, LSB first
    task automatic sendFrame(input logic [W-1:0] word, input bit rdy);
        tick(1'b0, 1'b0, 1'b0, rdy);
        for (int i = 0; i < W; i++) tick(1'b1, 1'b1, word[i], rdy);
    endtask

    // Pulse reset between clock edges and release it on a falling edge
    task automatic doReset();
        @(negedge clk);
        bus.i_enable    = 1'b0;
        bus.i_sync_n    = 1'b1;
        bus.i_in        = 1'b0;
        bus.i_out_ready = 1'b0;
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.o_data_out, bus.o_out_valid, bus.o_busy, bus.o_overrun} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got data=%h v=%b busy=%b ovr=%b, want all 0",
                     bus.o_data_out, bus.o_out_valid, bus.o_busy, bus.o_overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_ignores_enable: busy=%b valid=%b, want 0 0",
                     bus.o_busy, bus.o_out_valid);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] word;
        word = 4'hB;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy_after_sync: got %b want 1", bus.o_busy);
        end
        for (int i = 0; i < W; i++) tick(1'b1, 1'b1, word[i], 1'b0);
        checks++;
        if (bus.o_data_out !== 4'hB || bus.o_out_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_word: data=%h v=%b busy=%b, want B 1 0",
                     bus.o_data_out, bus.o_out_valid, bus.o_busy);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.o_out_valid !== 1'b0 || bus.o_data_out !== 4'hB) begin
            errors++;
            $display("[TB] FAIL basic_consume: v=%b data=%h, want 0 B",
                     bus.o_out_valid, bus.o_data_out);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] word;
        int           busyBad;
        word    = 4'hB;
        busyBad = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            tick(1'b1, 1'b1, word[i], 1'b0);
            if (i != W - 1) begin
                for (int g = 0; g < 3; g++) begin
                    tick(1'b0, 1'b1, 1'($urandom % 2), 1'b0);
                    if (bus.o_busy !== 1'b1) busyBad++;
                end
            end
        end
        checks++;
        if (busyBad != 0) begin
            errors++;
            $display("[TB] FAIL gapped_busy: busy low in %0d gap cycles, want 0", busyBad);
        end
        checks++;
        if (bus.o_data_out !== 4'hB || bus.o_out_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gapped_word: data=%h v=%b busy=%b, want B 1 0",
                     bus.o_data_out, bus.o_out_valid, bus.o_busy);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        sendFrame(4'hB, 1'b0);
        sendFrame(4'h6, 1'b0);
        checks++;
        if (bus.o_data_out !== 4'hB || bus.o_out_valid !== 1'b1 || bus.o_overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_drop: data=%h v=%b ovr=%b, want B 1 1",
                     bus.o_data_out, bus.o_out_valid, bus.o_overrun);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.o_out_valid !== 1'b0 || bus.o_overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: v=%b ovr=%b, want 0 1",
                     bus.o_out_valid, bus.o_overrun);
        end
    endtask

    task automatic test_consume_complete();
        logic [W-1:0] word;
        doReset();
        sendFrame(4'hB, 1'b0);
        word = 4'h6;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) tick(1'b1, 1'b1, word[i], 1'b0);
        tick(1'b1, 1'b1, word[W-1], 1'b1);
        checks++;
        if (bus.o_data_out !== 4'h6 || bus.o_out_valid !== 1'b1 || bus.o_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL consume_complete: data=%h v=%b ovr=%b, want 6 1 0",
                     bus.o_data_out, bus.o_out_valid, bus.o_overrun);
        end
    endtask

    task automatic test_resync();
        int rises;
        bit prevValid;
        doReset();
        rises     = 0;
        prevValid = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        if (bus.o_out_valid === 1'b1 && !prevValid) rises++;
        prevValid = bus.o_out_valid;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            tick(1'b1, 1'b1, (i == 2), 1'b0);
            if (bus.o_out_valid === 1'b1 && !prevValid) rises++;
            prevValid = bus.o_out_valid;
        end
        checks++;
        if (bus.o_data_out !== 4'h4 || rises != 1) begin
            errors++;
            $display("[TB] FAIL resync_word: data=%h rises=%0d, want 4 1",
                     bus.o_data_out, rises);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W - 1; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.o_out_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_beats_last_bit: v=%b busy=%b, want 0 1",
                     bus.o_out_valid, bus.o_busy);
        end
    endtask

    task automatic test_async_reset();
        sendFrame(4'h9, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checks++;
        if ({bus.o_data_out, bus.o_out_valid, bus.o_busy, bus.o_overrun} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_now: data=%h v=%b busy=%b ovr=%b, want all 0",
                     bus.o_data_out, bus.o_out_valid, bus.o_busy, bus.o_overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 1; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.o_out_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_waits_sync: v=%b busy=%b, want 0 0",
                     bus.o_out_valid, bus.o_busy);
        end
        sendFrame(4'hA, 1'b0);
        checks++;
        if (bus.o_data_out !== 4'hA || bus.o_out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset_recover: data=%h v=%b, want A 1",
                     bus.o_data_out, bus.o_out_valid);
        end
    endtask

    task automatic test_random();
        int localErr;
        doReset();
        localErr = 0;
        for (int n = 0; n < 600; n++) begin
            tick(1'(($urandom % 100) < 55), 1'(($urandom % 100) >= 8),
                 1'($urandom % 2), 1'(($urandom % 100) < 40));
            checks++;
            if (bus.o_data_out !== mData || bus.o_out_valid !== mValid ||
                bus.o_busy !== mActive || bus.o_overrun !== mOverrun) begin
                errors++;
                localErr++;
                if (localErr <= 5)
                    $display("[TB] FAIL random_step%0d: got data=%h v=%b busy=%b ovr=%b, want data=%h v=%b busy=%b ovr=%b",
                             n, bus.o_data_out, bus.o_out_valid, bus.o_busy, bus.o_overrun,
                             mData, mValid, mActive, mOverrun);
            end
        end
    endtask

    // Sequence of scenarios, then the single summary line
    initial begin
        errors          = 0;
        checks          = 0;
        rst             = 1'b1;
        bus.i_enable    = 1'b0;
        bus.i_sync_n    = 1'b1;
        bus.i_in        = 1'b0;
        bus.i_out_ready = 1'b0;
        modelReset();
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_consume_complete();
        test_resync();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-in, parallel-out receiver for the team's LSB-first shift-register link. It samples one bit per enabled clock edge and assembles WIDTH bits into a word. It then presents the word on a valid/ready output with sticky overrun detection. It sits at the far end of a parallel-in/serial-out transmitter that shares the same clock and bit-enable strobe.

## Interface
- WIDTH, 4: word width in bits; WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  bit strobe; the edge where it is high samples `in`.
- sync_n  input  1  active-low frame start, sampled on clk.
- in  input  1  serial data, LSB first.
- out_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  last completed word.
- out_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  frame in progress (state RECV).
- overrun  output  1  sticky: a completed word was dropped.

## Operation
- Reset is asynchronous and active-high. It is the only asynchronous path.
- Internal state:
  - shift register sh[WIDTH-1:0];
  - bit counter cnt, $clog2(WIDTH) bits;
  - FSM with states IDLE and RECV.
- Priority per clk edge: reset > sync_n > enable.
- In any state, sync_n=0 forces sh←0, cnt←0, state←RECV.
  - No bit is sampled that cycle, even if enable=1.
  - A partial frame is discarded silently. out_valid and overrun are unaffected.
- IDLE: enable and in are ignored, and sh/cnt hold.
- RECV with enable=1 and cnt<WIDTH-1: sh←{in, sh[WIDTH-1:1]}, cnt←cnt+1.
- RECV with enable=1 and cnt=WIDTH-1 completes the word {in, sh[WIDTH-1:1]}. On that edge, state←IDLE and cnt←0. The word is then handled by the output buffer rules.
- RECV with enable=0: hold everything.
- Output buffer, evaluated on every edge:
  - Consume: if out_valid=1 and out_ready=1, the word is accepted.
  - Complete, with no word pending or the pending word consumed this edge: data_out←new word, out_valid←1.
  - Complete, with out_valid=1 and out_ready=0: the new word is dropped, data_out is unchanged, overrun←1.
  - Consume without completion: out_valid←0 and data_out holds its value.
  - out_ready while out_valid=0 has no effect.
- overrun clears only on reset.
- Bit order: the first bit sampled after sync lands in data_out[0], the last in data_out[WIDTH-1].

## Timing
- Reset values:
  - data_out=0, out_valid=0, busy=0, overrun=0;
  - sh=0, cnt=0, state=IDLE.
- busy rises on the edge that samples sync_n=0. It falls on the edge that samples the final bit.
- Latency: out_valid and data_out update on the same edge that samples bit WIDTH-1. Both are visible immediately after that edge.
- Minimum frame time is 1 sync cycle plus WIDTH enabled cycles. The spacing of enable pulses is arbitrary.
- Throughput: back-to-back frames are supported. sync_n may be low on the cycle right after completion.
- Link contract: the transmitter loads on its sync cycle and presents bit 0 before its first shift. Each shared enable edge samples the current bit while the transmitter advances. No extra alignment cycle exists.
- Reset asserted mid-frame clears all state at once, without waiting for clk. After deassertion the block waits in IDLE for sync_n.
- sync_n and the final enabled bit in the same cycle: sync wins. The frame is discarded and no word is produced.

## Test plan
- Basic receive (WIDTH=4): sync_n pulse, then in=1,1,0,1 on four consecutive enabled edges. Required: data_out=4'hB and out_valid=1 after the 4th edge; busy=0 at that point.
- Gapped enable: same frame with enable low for 3 cycles between every bit. Required: identical result, with busy=1 throughout the gaps.
- Back-pressure and overrun:
  - Receive 4'hB with out_ready=0.
  - Then, still with out_ready=0, sync and receive 4'h6 (bits 0,1,1,0).
  - Required: data_out stays 4'hB and overrun=1.
  - Then raise out_ready: out_valid falls next edge and overrun stays 1.
- Simultaneous consume/complete: out_valid=1 holding 4'hB, with out_ready=1 on the edge of the last bit of 4'h6. Required: data_out=4'h6, out_valid=1, overrun=0.
- Resync mid-frame:
  - Sync, 2 bits (1,1), then sync again, then bits 0,0,1,0.
  - Required: data_out=4'h4 and only one out_valid rise.
  - Also: sync coincident with the final bit yields no word.
- Async reset mid-frame: assert reset between clk edges after 3 bits. Required: every output is 0 before the next edge, and later enables are ignored until sync_n.
